// File: rtl/mips_control_fsm.sv
// Multi-cycle MIPS control unit: sequences FETCH/DECODE/EXEC/MEM/WB and traps illegal instructions.
// Latency: 3 cycles (BEQ), 4 cycles (R-type/ADDI), 4+N cycles (SW) or 5+N cycles (LW) for N wait cycles.
// Backpressure: MEM holds while mem_ready is low; TRAP holds until reset.
module mips_control_fsm #(
    parameter int RETIRED_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [5:0]           opcode,
    input  logic [5:0]           func,
    input  logic                 zero,
    input  logic                 mem_ready,
    output logic                 RegWrite,
    output logic                 RegDst,
    output logic                 MemRead,
    output logic                 MemWrite,
    output logic                 ALUSrc,
    output logic                 MemToReg,
    output logic                 PCSrc,
    output logic [1:0]           ALUOp,
    output logic                 pc_en,
    output logic                 ir_en,
    output logic [2:0]           state,
    output logic [RETIRED_W-1:0] retired,
    output logic                 illegal
);

    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_MEM    = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_TRAP   = 3'd5;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] C_RTYPE   = 3'd0;
    localparam logic [2:0] C_ADDI    = 3'd1;
    localparam logic [2:0] C_LW      = 3'd2;
    localparam logic [2:0] C_SW      = 3'd3;
    localparam logic [2:0] C_BEQ     = 3'd4;
    localparam logic [2:0] C_ILLEGAL = 3'd7;

    localparam logic [1:0] ALU_ADD  = 2'b00;
    localparam logic [1:0] ALU_SUB  = 2'b01;
    localparam logic [1:0] ALU_FUNC = 2'b10;

    function automatic logic [2:0] classify(input logic [5:0] op, input logic [5:0] fn);
        logic [2:0] cls;
        cls = C_ILLEGAL;
        case (op)
            OP_RTYPE: begin
                if (fn == FN_ADD || fn == FN_SUB || fn == FN_AND ||
                    fn == FN_OR  || fn == FN_SLT) begin
                    cls = C_RTYPE;
                end
            end
            OP_ADDI: cls = C_ADDI;
            OP_LW:   cls = C_LW;
            OP_SW:   cls = C_SW;
            OP_BEQ:  cls = C_BEQ;
            default: cls = C_ILLEGAL;
        endcase
        return cls;
    endfunction

    logic [2:0]           state_q;
    logic [2:0]           state_d;
    logic [5:0]           op_q;
    logic [5:0]           fn_q;
    logic [RETIRED_W-1:0] retired_q;
    logic                 illegal_q;
    logic [2:0]           live_cls;
    logic [2:0]           lat_cls;
    logic                 in_datapath;

    // DECODE judges legality on the live instruction; later states only see the latched copy.
    assign live_cls = classify(opcode, func);
    assign lat_cls  = classify(op_q, fn_q);

    always_comb begin
        state_d = S_FETCH;
        case (state_q)
            S_FETCH:  state_d = S_DECODE;
            S_DECODE: state_d = (live_cls == C_ILLEGAL) ? S_TRAP : S_EXEC;
            S_EXEC: begin
                case (lat_cls)
                    C_RTYPE, C_ADDI: state_d = S_WB;
                    C_LW, C_SW:      state_d = S_MEM;
                    default:         state_d = S_FETCH;
                endcase
            end
            S_MEM: begin
                if (!mem_ready) begin
                    state_d = S_MEM;
                end else if (lat_cls == C_LW) begin
                    state_d = S_WB;
                end else begin
                    state_d = S_FETCH;
                end
            end
            S_WB:     state_d = S_FETCH;
            S_TRAP:   state_d = S_TRAP;
            default:  state_d = S_FETCH;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_FETCH;
            op_q      <= 6'd0;
            fn_q      <= 6'd0;
            retired_q <= '0;
            illegal_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_DECODE) begin
                op_q <= opcode;
                fn_q <= func;
                if (live_cls == C_ILLEGAL) begin
                    illegal_q <= 1'b1;
                end
            end
            if (pc_en) begin
                retired_q <= retired_q + {{(RETIRED_W-1){1'b0}}, 1'b1};
            end
        end
    end

    assign in_datapath = (state_q == S_EXEC) || (state_q == S_MEM) || (state_q == S_WB);

    always_comb begin
        RegWrite = 1'b0;
        RegDst   = 1'b0;
        MemRead  = 1'b0;
        MemWrite = 1'b0;
        ALUSrc   = 1'b0;
        MemToReg = 1'b0;
        PCSrc    = 1'b0;
        ALUOp    = ALU_ADD;
        pc_en    = 1'b0;
        ir_en    = 1'b0;

        if (in_datapath) begin
            ALUSrc = (lat_cls == C_ADDI) || (lat_cls == C_LW) || (lat_cls == C_SW);
            if (lat_cls == C_RTYPE) begin
                ALUOp = ALU_FUNC;
            end else if (lat_cls == C_BEQ) begin
                ALUOp = ALU_SUB;
            end
        end

        case (state_q)
            // Fetch strobe is withheld while reset is asserted; it appears once rst releases.
            S_FETCH: ir_en = rst;
            S_EXEC: begin
                if (lat_cls == C_BEQ) begin
                    PCSrc = zero;
                    pc_en = 1'b1;
                end
            end
            S_MEM: begin
                MemRead  = (lat_cls == C_LW);
                MemWrite = (lat_cls == C_SW);
                pc_en    = (lat_cls == C_SW) && mem_ready;
            end
            S_WB: begin
                RegWrite = 1'b1;
                RegDst   = (lat_cls == C_RTYPE);
                MemToReg = (lat_cls == C_RTYPE) || (lat_cls == C_ADDI);
                pc_en    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    assign state   = state_q;
    assign retired = retired_q;
    assign illegal = illegal_q;

endmodule
